game_level_sequencer: RTL and testbench

Parametrised top-level game flow controller, successor to the fixed two-level game FSM. It sequences start screen, N playable levels, inter-level transition, victory and death. It counts enemy kills per level, including multiple kills in one cycle, and times the inter-level pause with an internal slowClk tick counter. It sits between the collision/life logic and the screen, enemy and tree generators.

---
 rtl/game_pkg.sv | 31 +++
 rtl/game_level_sequencer_if.sv | 44 ++++
 rtl/game_tick_timer.sv | 39 +++
 rtl/game_level_sequencer.sv | 135 +++++++++++++
 tb/tb_game_level_sequencer.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared types and helpers for the game level sequencer: state encodings and kill popcount.
// The PAUSED encoding exists only when GAME_PAUSE_EN is defined.
package game_pkg;

    localparam int KILL_MAX_W = 8;

    typedef enum logic [2:0] {
        ST_START      = 3'd0,
        ST_PLAY       = 3'd1,
        ST_INTERLEVEL = 3'd2,
        ST_VICTORY    = 3'd4,
        ST_DEATH      = 3'd5,
`ifdef GAME_PAUSE_EN
        ST_TRANSITION = 3'd6,
        ST_PAUSED     = 3'd7
`else
        ST_TRANSITION = 3'd6
`endif
    } game_state_e;

    // Every set strobe bit is one kill, so several enemies can die in one cycle.
    function automatic logic [3:0] kill_count(input logic [KILL_MAX_W-1:0] strobes);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < KILL_MAX_W; i++) begin
            n = n + {3'b000, strobes[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/game_level_sequencer_if.sv
// Bundle between the collision/life logic, the sequencer and the screen/enemy/tree generators.
// playerPause is present only when GAME_PAUSE_EN is defined.
interface game_level_sequencer_if #(
    parameter int KILL_W = 3
);
    logic [2:0]        currLife;
    logic [KILL_W-1:0] shotEnemyCollision;
    logic              slowClk;
    logic              playerTrigger;
    logic              transitionDone;
`ifdef GAME_PAUSE_EN
    logic              playerPause;
`endif
    logic [2:0]        currentGameState;
    logic [2:0]        level;
    logic [2:0]        enemies_remaining;
    logic [10:0]       curEnemySpeed;
    logic [3:0]        tree_count;
    logic              pause;
    logic              start_screen;
    logic              death_screen;
    logic              transition_screen;
    logic              victory_screen;
    logic              newLevel;

    modport master (
`ifdef GAME_PAUSE_EN
        output playerPause,
`endif
        output currLife, shotEnemyCollision, slowClk, playerTrigger, transitionDone,
        input  currentGameState, level, enemies_remaining, curEnemySpeed, tree_count,
        input  pause, start_screen, death_screen, transition_screen, victory_screen, newLevel
    );

    modport slave (
`ifdef GAME_PAUSE_EN
        input  playerPause,
`endif
        input  currLife, shotEnemyCollision, slowClk, playerTrigger, transitionDone,
        output currentGameState, level, enemies_remaining, curEnemySpeed, tree_count,
        output pause, start_screen, death_screen, transition_screen, victory_screen, newLevel
    );

endinterface

// File: rtl/game_tick_timer.sv
// Loadable slowClk strobe counter; done pulses on the strobe that completes TICKS counts.
module game_tick_timer #(
    parameter int TICKS = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    input  logic tick,
    output logic done
);

    localparam int CNT_W = (TICKS < 2) ? 1 : $clog2(TICKS + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        // Load wins so a strobe in the loading cycle is never counted.
        if (load) begin
            cnt_d = '0;
        end else if (en && tick && (cnt_q < CNT_W'(TICKS))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign done = en && !load && tick && (cnt_q == CNT_W'(TICKS - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/game_level_sequencer.sv
// Top-level game flow: start, N levels, transition/interlevel wait, victory and death.
// Optional pause support is enabled with the GAME_PAUSE_EN macro.
module game_level_sequencer
    import game_pkg::*;
#(
    parameter int NUM_LEVELS        = 2,
    parameter int ENEMIES_PER_LEVEL = 2,
    parameter int KILL_W            = 3,
    parameter int BASE_SPEED        = 120,
    parameter int SPEED_STEP        = 120,
    parameter int TREE_COUNT        = 8,
    parameter int TRANSITION_TICKS  = 1
) (
    input logic                  clk,
    input logic                  resetN,
    game_level_sequencer_if.slave bus
);

    localparam logic [2:0] ENEMY_RELOAD = 3'(ENEMIES_PER_LEVEL);
    localparam logic [2:0] LAST_LEVEL   = 3'(NUM_LEVELS - 1);

    game_state_e state_q, state_d;
    logic [2:0]  level_q, level_d;
    logic [2:0]  enemies_q, enemies_d;
    logic        new_level_q, new_level_d;
    logic [3:0]  kills;
    logic [2:0]  enemies_after;
    logic        timer_load;
    logic        timer_done;

    game_tick_timer #(
        .TICKS (TRANSITION_TICKS)
    ) u_tick_timer (
        .clk   (clk),
        .rst_n (resetN),
        .load  (timer_load),
        .en    (state_q == ST_INTERLEVEL),
        .tick  (bus.slowClk),
        .done  (timer_done)
    );

    assign kills         = kill_count(KILL_MAX_W'(bus.shotEnemyCollision));
    assign enemies_after = (kills >= {1'b0, enemies_q}) ? 3'd0 : (enemies_q - kills[2:0]);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        enemies_d  = enemies_q;
        timer_load = 1'b0;
        unique case (state_q)
            ST_START: begin
                level_d   = '0;
                enemies_d = ENEMY_RELOAD;
                if (bus.playerTrigger) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (bus.currLife == 3'd0) begin
                    state_d = ST_DEATH;
`ifdef GAME_PAUSE_EN
                end else if (bus.playerPause) begin
                    state_d = ST_PAUSED;
`endif
                end else begin
                    enemies_d = enemies_after;
                    if (enemies_after == 3'd0) begin
                        state_d = (level_q == LAST_LEVEL) ? ST_VICTORY : ST_TRANSITION;
                    end
                end
            end
            ST_TRANSITION: begin
                if (bus.transitionDone) begin
                    state_d    = ST_INTERLEVEL;
                    timer_load = 1'b1;
                end
            end
            ST_INTERLEVEL: begin
                if (timer_done) begin
                    state_d   = ST_PLAY;
                    level_d   = level_q + 3'd1;
                    enemies_d = ENEMY_RELOAD;
                end
            end
            ST_VICTORY, ST_DEATH: begin
                if (bus.playerTrigger) begin
                    state_d   = ST_START;
                    level_d   = '0;
                    enemies_d = ENEMY_RELOAD;
                end
            end
`ifdef GAME_PAUSE_EN
            ST_PAUSED: begin
                if (bus.playerPause) begin
                    state_d = (bus.currLife == 3'd0) ? ST_DEATH : ST_PLAY;
                end
            end
`endif
            default: begin
                state_d   = ST_START;
                level_d   = '0;
                enemies_d = ENEMY_RELOAD;
            end
        endcase
        // Resuming from pause is not a new level, so only these two predecessors pulse.
        new_level_d = (state_d == ST_PLAY) &&
                      ((state_q == ST_START) || (state_q == ST_INTERLEVEL));
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= ST_START;
            level_q     <= '0;
            enemies_q   <= ENEMY_RELOAD;
            new_level_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            enemies_q   <= enemies_d;
            new_level_q <= new_level_d;
        end
    end

    assign bus.currentGameState  = state_q;
    assign bus.level             = level_q;
    assign bus.enemies_remaining = enemies_q;
    assign bus.newLevel          = new_level_q;
    assign bus.curEnemySpeed     = 11'(BASE_SPEED + int'(level_q) * SPEED_STEP);
    assign bus.tree_count        = (state_q == ST_PLAY) ? 4'(TREE_COUNT) : 4'd0;
    assign bus.pause             = (state_q != ST_PLAY);
    assign bus.start_screen      = (state_q == ST_START);
    assign bus.transition_screen = (state_q == ST_TRANSITION);
    assign bus.death_screen      = (state_q == ST_DEATH);
    assign bus.victory_screen    = (state_q == ST_VICTORY);

endmodule

// File: tb/tb_game_level_sequencer.sv
// Directed bench: default two-level instance plus a three-level, four-tick-wait instance.
// Pause checks are compiled in when GAME_PAUSE_EN is defined.
module tb_game_level_sequencer;

    logic clk;
    logic resetN;
    int   checks;
    int   failures;

    game_level_sequencer_if #(.KILL_W(3)) ifa ();
    game_level_sequencer_if #(.KILL_W(3)) ifb ();

    game_level_sequencer dut_a (
        .clk    (clk),
        .resetN (resetN),
        .bus    (ifa.slave)
    );

    game_level_sequencer #(
        .NUM_LEVELS       (3),
        .TRANSITION_TICKS (4)
    ) dut_b (
        .clk    (clk),
        .resetN (resetN),
        .bus    (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_a();
        ifa.playerTrigger      = 1'b0;
        ifa.shotEnemyCollision = 3'b000;
        ifa.slowClk            = 1'b0;
        ifa.transitionDone     = 1'b0;
`ifdef GAME_PAUSE_EN
        ifa.playerPause        = 1'b0;
`endif
    endtask

    task automatic clear_b();
        ifb.playerTrigger      = 1'b0;
        ifb.shotEnemyCollision = 3'b000;
        ifb.slowClk            = 1'b0;
        ifb.transitionDone     = 1'b0;
`ifdef GAME_PAUSE_EN
        ifb.playerPause        = 1'b0;
`endif
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        resetN   = 1'b0;
        clear_a();
        clear_b();
        ifa.currLife = 3'd3;
        ifb.currLife = 3'd3;
        #12;

        check("rst_state",      ifa.currentGameState, 0);
        check("rst_level",      ifa.level, 0);
        check("rst_enemies",    ifa.enemies_remaining, 2);
        check("rst_speed",      ifa.curEnemySpeed, 120);
        check("rst_tree",       ifa.tree_count, 0);
        check("rst_newlevel",   ifa.newLevel, 0);
        check("rst_pause",      ifa.pause, 1);
        check("rst_start_scr",  ifa.start_screen, 1);
        check("rst_death_scr",  ifa.death_screen, 0);
        check("rst_trans_scr",  ifa.transition_screen, 0);
        check("rst_vict_scr",   ifa.victory_screen, 0);
        check("rst_b_state",    ifb.currentGameState, 0);

        resetN = 1'b1;
        ifa.shotEnemyCollision = 3'b111;
        tick();
        check("start_kill_state",   ifa.currentGameState, 0);
        check("start_kill_enemies", ifa.enemies_remaining, 2);

        clear_a();
        ifa.playerTrigger = 1'b1;
        tick();
        check("trig_state",    ifa.currentGameState, 1);
        check("trig_newlevel", ifa.newLevel, 1);
        check("trig_level",    ifa.level, 0);
        check("trig_enemies",  ifa.enemies_remaining, 2);
        check("trig_speed",    ifa.curEnemySpeed, 120);
        check("trig_tree",     ifa.tree_count, 8);
        check("trig_pause",    ifa.pause, 0);
        check("trig_start",    ifa.start_screen, 0);

        clear_a();
        tick();
        check("newlevel_drop", ifa.newLevel, 0);
        check("play_hold",     ifa.currentGameState, 1);

        ifa.shotEnemyCollision = 3'b011;
        tick();
        check("double_kill_enemies", ifa.enemies_remaining, 0);
        check("double_kill_state",   ifa.currentGameState, 6);
        check("trans_screen",        ifa.transition_screen, 1);
        check("trans_pause",         ifa.pause, 1);
        check("trans_tree",          ifa.tree_count, 0);

        clear_a();
        ifa.slowClk = 1'b1;
        tick();
        check("trans_ignores_tick", ifa.currentGameState, 6);

        ifa.transitionDone = 1'b1;
        ifa.slowClk        = 1'b1;
        tick();
        check("interlevel_entry", ifa.currentGameState, 2);

        clear_a();
        tick();
        check("entry_tick_not_counted", ifa.currentGameState, 2);

        ifa.slowClk = 1'b1;
        tick();
        check("lvl1_state",    ifa.currentGameState, 1);
        check("lvl1_level",    ifa.level, 1);
        check("lvl1_enemies",  ifa.enemies_remaining, 2);
        check("lvl1_speed",    ifa.curEnemySpeed, 240);
        check("lvl1_newlevel", ifa.newLevel, 1);

        clear_a();
        tick();
        check("lvl1_newlevel_drop", ifa.newLevel, 0);

        ifa.shotEnemyCollision = 3'b100;
        tick();
        check("single_kill_enemies", ifa.enemies_remaining, 1);
        check("single_kill_state",   ifa.currentGameState, 1);

        ifa.shotEnemyCollision = 3'b111;
        tick();
        check("saturate_enemies", ifa.enemies_remaining, 0);
        check("victory_state",    ifa.currentGameState, 4);
        check("victory_screen",   ifa.victory_screen, 1);

        tick();
        check("victory_ignores_kill", ifa.currentGameState, 4);

        clear_a();
        ifa.playerTrigger = 1'b1;
        tick();
        check("vict_to_start",    ifa.currentGameState, 0);
        check("vict_start_level", ifa.level, 0);
        check("vict_start_enem",  ifa.enemies_remaining, 2);

        tick();
        check("restart_play", ifa.currentGameState, 1);

        clear_a();
        ifa.shotEnemyCollision = 3'b001;
        tick();
        check("pre_death_enemies", ifa.enemies_remaining, 1);

        ifa.shotEnemyCollision = 3'b010;
        ifa.currLife           = 3'd0;
        tick();
        check("death_priority", ifa.currentGameState, 5);
        check("death_screen",   ifa.death_screen, 1);

        clear_a();
        ifa.currLife      = 3'd3;
        ifa.playerTrigger = 1'b1;
        tick();
        check("death_to_start", ifa.currentGameState, 0);
        check("death_level",    ifa.level, 0);

`ifdef GAME_PAUSE_EN
        tick();
        check("pause_setup_play", ifa.currentGameState, 1);
        clear_a();
        ifa.shotEnemyCollision = 3'b001;
        tick();
        clear_a();
        ifa.playerPause = 1'b1;
        tick();
        check("paused_state", ifa.currentGameState, 7);
        check("paused_flag",  ifa.pause, 1);
        clear_a();
        ifa.shotEnemyCollision = 3'b011;
        tick();
        check("paused_kill_enemies", ifa.enemies_remaining, 1);
        check("paused_kill_state",   ifa.currentGameState, 7);
        clear_a();
        ifa.currLife = 3'd0;
        tick();
        check("paused_ignores_death", ifa.currentGameState, 7);
        ifa.currLife    = 3'd3;
        ifa.playerPause = 1'b1;
        tick();
        check("resume_state",    ifa.currentGameState, 1);
        check("resume_newlevel", ifa.newLevel, 0);
        check("resume_enemies",  ifa.enemies_remaining, 1);
        clear_a();
`else
        tick();
        clear_a();
`endif

        check("async_pre_state", ifa.currentGameState, 1);
        resetN = 1'b0;
        #1;
        check("async_rst_state", ifa.currentGameState, 0);
        check("async_rst_start", ifa.start_screen, 1);
        check("async_rst_enem",  ifa.enemies_remaining, 2);
        #2;
        resetN = 1'b1;
        tick();

        ifb.playerTrigger = 1'b1;
        tick();
        check("b_play", ifb.currentGameState, 1);
        clear_b();
        ifb.shotEnemyCollision = 3'b011;
        tick();
        check("b_transition", ifb.currentGameState, 6);
        clear_b();
        ifb.transitionDone = 1'b1;
        tick();
        check("b_interlevel", ifb.currentGameState, 2);
        clear_b();
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("b_idle_hold", ifb.currentGameState, 2);
            ifb.slowClk = 1'b1;
            tick();
            ifb.slowClk = 1'b0;
            check($sformatf("b_after_tick%0d", i), ifb.currentGameState, (i < 4) ? 2 : 1);
        end
        check("b_lvl1_level",    ifb.level, 1);
        check("b_lvl1_speed",    ifb.curEnemySpeed, 240);
        check("b_lvl1_newlevel", ifb.newLevel, 1);
        ifb.shotEnemyCollision = 3'b011;
        tick();
        check("b_lvl1_clear_state", ifb.currentGameState, 6);
        check("b_lvl1_clear_level", ifb.level, 1);
        clear_b();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
